rr_arbiter_param: RTL and testbench

Parametrised round-robin arbiter with a registered grant and a registered priority pointer. It serves NUM_REQ requesters; the router instantiates five, one each for N, S, W, E and L. A grant is held (locked) until the owner releases it, drops its request, or exceeds a configurable hold limit. The binary grant index drives the crossbar mux select; the one-hot grant returns to the input ports.

---
 rtl/rr_arbiter_param.sv | 151 +++++++++++++++
 tb/tb_rr_arbiter_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with a locked, registered grant. The search starts at the
// pointer from IDLE, and at owner+1 on rearbitration, so the old owner is considered last.
module rr_arbiter_param #(
  parameter int NUM_REQ  = 5,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  input  logic               restart_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]    NUM_EXT  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;

  logic [IDX_W-1:0]   next_after_owner;
  logic [IDX_W-1:0]   search_start;
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_found;
  logic               hold_expired;
  logic               rearb;

  // cand_idx[k] is the k-th requester visited when searching from search_start.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum           = {1'b0, search_start} + (IDX_W + 1)'(gi);
    assign cand_idx[gi]  = (sum >= NUM_EXT) ? IDX_W'(sum - NUM_EXT) : sum[IDX_W-1:0];
    assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
  end

  // Walk the order backwards so the earliest requester is the last one assigned.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[cand_idx[i]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    next_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    hold_expired     = (MAX_HOLD != 0) && (hcnt_q == HOLD_LIM);
    rearb            = (state_q == LOCKED) &&
                       (release_i || !req_i[owner_q] || hold_expired);
    search_start     = (state_q == LOCKED) ? next_after_owner : ptr_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;

    if (restart_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      owner_d = '0;
      hcnt_d  = '0;
      gnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d = LOCKED;
            owner_d = win_idx;
            hcnt_d  = HOLD_ONE;
            gnt_d   = win_onehot;
            valid_d = 1'b1;
          end else begin
            owner_d = '0;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
        LOCKED: begin
          if (rearb) begin
            ptr_d = next_after_owner;
            if (win_found) begin
              owner_d = win_idx;
              hcnt_d  = HOLD_ONE;
              gnt_d   = win_onehot;
              valid_d = 1'b1;
            end else begin
              state_d = IDLE;
              owner_d = '0;
              hcnt_d  = '0;
              gnt_d   = '0;
              valid_d = 1'b0;
            end
          end else if ((MAX_HOLD != 0) && (hcnt_q != HOLD_LIM)) begin
            hcnt_d = hcnt_q + HOLD_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          owner_d = '0;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hcnt_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = owner_q;
  assign gnt_valid_o = valid_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Self-checking bench: directed vector table on a 5-port arbiter, a hold-limit run
// (MAX_HOLD=4) and a randomized 8-port run checking grant invariants and fairness.
module tb_rr_arbiter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [4:0] req5, gnt5;
  logic       rel5, rs5, vld5;
  logic [2:0] idx5;

  logic [4:0] req_h, gnt_h;
  logic       rel_h, rs_h, vld_h;
  logic [2:0] idx_h;

  logic [7:0] req8, gnt8;
  logic       rel8, rs8, vld8;
  logic [2:0] idx8;

  rr_arbiter_param #(.NUM_REQ(5), .MAX_HOLD(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_i(req5), .release_i(rel5), .restart_i(rs5),
    .gnt_o(gnt5), .gnt_idx_o(idx5), .gnt_valid_o(vld5));

  rr_arbiter_param #(.NUM_REQ(5), .MAX_HOLD(4)) dut_h (
    .clk(clk), .rst_n(rst_n), .req_i(req_h), .release_i(rel_h), .restart_i(rs_h),
    .gnt_o(gnt_h), .gnt_idx_o(idx_h), .gnt_valid_o(vld_h));

  rr_arbiter_param #(.NUM_REQ(8), .MAX_HOLD(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_i(req8), .release_i(rel8), .restart_i(rs8),
    .gnt_o(gnt8), .gnt_idx_o(idx8), .gnt_valid_o(vld8));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] req;
    logic       rel;
    logic       rs;
    logic       vld;
    logic [2:0] idx;
  } vec_t;

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    logic [4:0] gnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic [4:0] r, input logic l, input logic s,
                              input logic v, input logic [2:0] i);
    vec_t t;
    t.req = r; t.rel = l; t.rs = s; t.vld = v; t.idx = i;
    vecs.push_back(t);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic exp_t make_exp(input logic v, input logic [2:0] i);
    exp_t e;
    logic [4:0] one;
    one   = 5'b00001;
    e.vld = v;
    e.idx = v ? i : 3'd0;
    e.gnt = v ? (one << i) : 5'b00000;
    return e;
  endfunction

  // Drive one vector, wait one edge, then compare against the queued expectation.
  task automatic step5(input vec_t v, input string tag);
    exp_t e;
    req5 = v.req; rel5 = v.rel; rs5 = v.rs;
    sb.push_back(make_exp(v.vld, v.idx));
    @(posedge clk); #1;
    e = sb.pop_front();
    $display("%s req=%b rel=%b rs=%b -> vld=%b idx=%0d gnt=%b", tag, v.req, v.rel, v.rs, vld5, idx5, gnt5);
    check({tag, "_vld"}, 32'(vld5), 32'(e.vld));
    check({tag, "_idx"}, 32'(idx5), 32'(e.idx));
    check({tag, "_gnt"}, 32'(gnt5), 32'(e.gnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   waitc[8];
    int   maxw;
    logic prev_vld;
    logic [2:0] prev_idx;
    logic newg;

    rst_n = 1'b0;
    req5 = '0; rel5 = 1'b0; rs5 = 1'b0;
    req_h = '0; rel_h = 1'b0; rs_h = 1'b0;
    req8 = '0; rel8 = 1'b0; rs8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_vld", 32'(vld5), 32'd0);
    check("reset_gnt", 32'(gnt5), 32'd0);
    check("reset_idx", 32'(idx5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full request with release every cycle: 0,1,2,3,4,0
    add(5'b11111, 0, 0, 1, 0);
    add(5'b11111, 1, 0, 1, 1);
    add(5'b11111, 1, 0, 1, 2);
    add(5'b11111, 1, 0, 1, 3);
    add(5'b11111, 1, 0, 1, 4);
    add(5'b11111, 1, 0, 1, 0);
    // Owner 2 locked for 10 cycles, then release hands over to 0
    add(5'b00101, 1, 0, 1, 2);
    for (int i = 0; i < 10; i++) add(5'b00101, 0, 0, 1, 2);
    add(5'b00101, 1, 0, 1, 0);
    // Sole requester 3 regranted, then release with nothing pending
    add(5'b01000, 0, 0, 1, 3);
    add(5'b01000, 1, 0, 1, 3);
    add(5'b00000, 1, 0, 0, 0);
    add(5'b00000, 1, 0, 0, 0);
    // From IDLE the pointer sits at 4 and release is ignored
    add(5'b01000, 1, 0, 1, 3);
    // Restart beats release; the pointer returns to 0
    add(5'b11111, 1, 1, 0, 0);
    add(5'b11111, 0, 0, 1, 0);
    add(5'b00000, 0, 0, 0, 0);
    add(5'b11111, 0, 0, 1, 1);
    add(5'b11111, 1, 0, 1, 2);
    add(5'b11000, 0, 0, 1, 3);
    add(5'b11000, 0, 0, 1, 3);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step5(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset between edges while owner 3 (pointer 3) is granted
    #2;
    rst_n = 1'b0;
    #1;
    $display("async_rst -> vld=%b idx=%0d gnt=%b", vld5, idx5, gnt5);
    check("async_rst_vld", 32'(vld5), 32'd0);
    check("async_rst_gnt", 32'(gnt5), 32'd0);
    check("async_rst_idx", 32'(idx5), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v.req = 5'b11111; v.rel = 1'b0; v.rs = 1'b0; v.vld = 1'b1; v.idx = 3'd0;
    step5(v, "post_rst");
    req5 = '0;

    // Hold limit 4 with two requesters alternating
    @(negedge clk);
    req_h = 5'b00011;
    for (int k = 0; k < 12; k++) begin
      sb.push_back(make_exp(1'b1, 3'((k / 4) % 2)));
      @(posedge clk); #1;
      e = sb.pop_front();
      $display("hold%0d req=%b -> vld=%b idx=%0d gnt=%b", k, req_h, vld_h, idx_h, gnt_h);
      check($sformatf("hold%0d_vld", k), 32'(vld_h), 32'(e.vld));
      check($sformatf("hold%0d_idx", k), 32'(idx_h), 32'(e.idx));
      check($sformatf("hold%0d_gnt", k), 32'(gnt_h), 32'(e.gnt));
    end
    req_h = '0;
    @(posedge clk); #1;
    check("hold_idle_vld", 32'(vld_h), 32'd0);

    // Randomized 8-port run
    for (int k = 0; k < 8; k++) waitc[k] = 0;
    prev_vld = 1'b0;
    prev_idx = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) req8 = 8'($urandom);
      rel8 = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      $display("r8_%0d req=%b rel=%b -> vld=%b idx=%0d gnt=%b", c, req8, rel8, vld8, idx8, gnt8);
      check($sformatf("r8_%0d_onehot", c),
            32'(vld8 ? (($countones(gnt8) == 1) && gnt8[idx8]) : ((gnt8 == 8'd0) && (idx8 == 3'd0))), 32'd1);
      check($sformatf("r8_%0d_vld", c), 32'(vld8), 32'(|req8));
      newg = vld8 && (!prev_vld || (idx8 != prev_idx));
      maxw = 0;
      for (int k = 0; k < 8; k++) begin
        if (!req8[k] || (vld8 && (idx8 == 3'(k)))) waitc[k] = 0;
        else if (newg) waitc[k]++;
        if (waitc[k] > maxw) maxw = waitc[k];
      end
      check($sformatf("r8_%0d_fair", c), 32'(maxw <= 8), 32'd1);
      prev_vld = vld8;
      prev_idx = idx8;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
